// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_pkg
// Brief  : Shared UART definitions: FSM encoding and bit-timing helpers.
// Rev    : 1.0
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A one-cycle bit period still needs a 1-bit counter
    function automatic int clk_cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_if
// Brief  : Byte-stream valid/ready handshake into the UART transmitter.
// Rev    : 1.0
// ============================================================================
interface uart_tx_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with first-word-fall-through read data.
// Rev    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : Buffered 8N1 UART transmitter with valid/ready byte input.
// Rev    : 1.0
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_if.slave                      in_bus,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int                CNT_W        = clk_cnt_width(CLKS_PER_BIT);
    localparam int                CNT_BITS     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(FIFO_DEPTH);

    uart_state_t        r_state;
    uart_state_t        w_state_next;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [CNT_W-1:0]   w_clk_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               r_busy;
    logic               r_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_bit_end;
    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_BITS-1:0] w_count;
    logic [CNT_BITS-1:0] w_count_next;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_bus.in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_push       = in_bus.in_valid && r_ready && !w_full;
    assign w_bit_end    = (r_clk_cnt == BIT_LAST);
    assign w_count_next = w_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);

    // tx is registered from the current state, so the line lags the FSM by one cycle
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_tx_next      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                w_tx_next = r_shift[r_bit_idx];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_idx == LAST_BIT_IDX) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= (r_state != ST_IDLE) || !w_empty;
            r_ready   <= (w_count_next < FULL_COUNT);
        end
    end

    assign in_bus.in_ready = r_ready;
    assign tx              = r_tx;
    assign busy            = r_busy;
    assign fifo_count      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_uart_tx
// Brief  : Directed bench for uart_tx with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx;

    localparam int TB_CLK_FREQ = 1_000_000;
    localparam int TB_BAUD     = 140_000;
    localparam int DEPTH       = 16;
    localparam int C           = 7;   // 1_000_000 / 140_000 truncated

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    uart_tx_if bus();

    uart_tx #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .BAUD_RATE  (TB_BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bus     (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a queued byte is taken once the previous frame's
    // ten bit periods have elapsed; its frame appears on tx one cycle later.
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] m_byte;
    int         m_pop_edge  = 0;
    bit         m_has_frame = 0;
    logic       e_tx    = 1'b1;
    logic       e_ready = 1'b0;
    logic       e_busy  = 1'b0;
    int         e_count = 0;
    int         cyc     = 0;
    int         rst_gen = 0;
    bit         chk_en  = 0;
    int         rx_count = 0;
    logic [7:0] rx_last  = '0;

    initial begin : model
        bit acc;
        bit pop;
        bit active;
        int k;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                exp_rx.delete();
                m_has_frame = 0;
                e_tx = 1'b1; e_ready = 1'b0; e_busy = 1'b0; e_count = 0;
                rst_gen++;
            end else begin
                acc    = bus.in_valid && e_ready;
                active = m_has_frame && (cyc > m_pop_edge) && (cyc <= m_pop_edge + 10 * C);
                pop    = (mq.size() > 0) && (!m_has_frame || cyc >= m_pop_edge + 10 * C);
                if (active) begin
                    k = (cyc - m_pop_edge - 1) / C;
                    if (k == 0)      e_tx = 1'b0;
                    else if (k == 9) e_tx = 1'b1;
                    else             e_tx = m_byte[k-1];
                end else begin
                    e_tx = 1'b1;
                end
                e_busy = active || (mq.size() > 0);
                if (pop) begin
                    m_byte = mq.pop_front();
                    m_pop_edge = cyc;
                    m_has_frame = 1;
                    exp_rx.push_back(m_byte);
                end
                if (acc) mq.push_back(bus.in_data);
                e_count = mq.size();
                e_ready = (e_count < DEPTH);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx", tx, e_tx);
                check("in_ready", bus.in_ready, e_ready);
                check("busy", busy, e_busy);
                check("fifo_count", fifo_count, e_count);
            end
        end
    end

    // Mid-bit sampling receiver fed by the serial line
    initial begin : rx_loopback
        int t;
        int k;
        int gen;
        bit act;
        logic [7:0] b;
        logic [7:0] e;
        t = 0; gen = 0; act = 0; b = '0;
        forever begin
            @(negedge clk);
            if (gen != rst_gen) begin
                gen = rst_gen;
                act = 0;
            end else if (!act) begin
                if (chk_en && tx === 1'b0) begin
                    act = 1;
                    t = 0;
                end
            end else begin
                t++;
                if (t % C == C / 2) begin
                    k = t / C;
                    if (k == 0) begin
                        check("rx_start", tx, 0);
                    end else if (k <= 8) begin
                        b[k-1] = tx;
                    end else begin
                        check("rx_stop", tx, 1);
                        if (exp_rx.size() > 0) begin
                            e = exp_rx.pop_front();
                            check("rx_data", b, e);
                        end else begin
                            check("rx_pending", exp_rx.size(), 1);
                        end
                        rx_count++;
                        rx_last = b;
                        act = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_count !== 5'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {busy, fifo_count}, 0);
    endtask

    initial begin : main
        int base;
        int n;
        logic [9:0] pat;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        chk_en = 1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);

        // Single byte 0x55: latency, bit pattern, busy window
        bus.in_valid = 1'b1; bus.in_data = 8'h55;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_data = 8'hFF;
        check("t1_count_n", fifo_count, 1);
        check("t1_tx_n", tx, 1);
        @(negedge clk);
        check("t1_tx_n1", tx, 1);
        check("t1_busy_n1", busy, 1);
        check("t1_count_n1", fifo_count, 0);
        @(negedge clk);
        pat = 10'b1010101010;
        check("t1_bit0", tx, pat[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (C) @(negedge clk);
            check("t1_bit", tx, pat[k]);
        end
        repeat (C - 1) @(negedge clk);
        check("t1_busy_last", busy, 1);
        @(negedge clk);
        check("t1_busy_end", busy, 0);
        wait_idle(100);

        // Back-to-back 0xA3, 0x0F: contiguous frames
        bus.in_valid = 1'b1; bus.in_data = 8'hA3;
        @(negedge clk);
        bus.in_data = 8'h0F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t2_count", fifo_count, 1);
        @(negedge clk);
        check("t2_start1", tx, 0);
        repeat (10 * C - 1) @(negedge clk);
        check("t2_stop1", tx, 1);
        @(negedge clk);
        check("t2_start2", tx, 0);
        check("t2_count2", fifo_count, 0);
        repeat (10 * C - 1) @(negedge clk);
        check("t2_busy_last", busy, 1);
        @(negedge clk);
        check("t2_busy_end", busy, 0);
        wait_idle(100);

        // in_valid held for 20 cycles, then a push attempt on the pop edge
        base = rx_count;
        for (int i = 0; i < 20; i++) begin
            check("fill_ready", bus.in_ready, (i < 17) ? 32'd1 : 32'd0);
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("fill_count", fifo_count, 16);
        repeat (51) @(negedge clk);
        check("full_ready", bus.in_ready, 0);
        check("full_count", fifo_count, 16);
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pop_edge_count", fifo_count, 15);
        check("pop_edge_ready", bus.in_ready, 1);
        wait_idle(2000);
        check("fill_rx_count", rx_count - base, 17);
        check("fill_rx_last", rx_last, 8'h10);

        // Reset during data bit 3 with five bytes queued
        base = rx_count;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'h30 + 8'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("mr_count", fifo_count, 5);
        repeat (26) @(negedge clk);
        check("mr_bit3", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_tx", tx, 1);
        check("mr_count0", fifo_count, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_ready1", bus.in_ready, 1);
        repeat (15 * C) @(negedge clk);
        check("mr_quiet_tx", tx, 1);
        check("mr_no_frames", rx_count - base, 0);

        // Loopback of all byte values
        base = rx_count;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("lb_ready_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b1; bus.in_data = 8'(v);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        wait_idle(2000);
        check("lb_rx_count", rx_count - base, 256);
        check("lb_rx_last", rx_last, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 8 bits: byte to transmit.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: buffer can accept a byte.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high when a frame is in progress or the buffer is non-empty.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of occupied buffer entries.

Function
REQ-012 SHALL accept a byte on any rising edge where in_valid and in_ready are both high; in_data SHALL be written to the buffer tail.
REQ-013 SHALL drive in_ready = (fifo_count < FIFO_DEPTH), registered; a pop in the same cycle SHALL NOT make a full buffer accept.
REQ-014 SHALL drop in_valid while in_ready is low, with no side effect.
REQ-015 SHALL use CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division); every bit SHALL be held on tx for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL send each frame as: start bit 0, 8 data bits LSB first, stop bit 1 (8N1), for 10*CLKS_PER_BIT cycles total.
REQ-017 SHALL implement the states IDLE, START, DATA and STOP.
REQ-018 SHALL behave in IDLE as follows: tx=1; if the buffer is non-empty, pop the head into a shift register and go to START.
REQ-019 SHALL behave in START as follows: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-020 SHALL behave in DATA as follows: tx = shift[bit index] for CLKS_PER_BIT cycles; after index 7, go to STOP.
REQ-021 SHALL behave in STOP as follows: tx=1 for CLKS_PER_BIT cycles; then, if the buffer is non-empty, pop and go to START directly with no idle gap, else go to IDLE.
REQ-022 SHALL give a latency, with an empty buffer and IDLE, such that a byte accepted on edge N makes tx fall at edge N+2.
REQ-023 SHALL register tx with no glitches and change it only on bit boundaries.
REQ-024 SHALL wrap the buffer read and write pointers modulo FIFO_DEPTH; fifo_count SHALL track push-only +1, pop-only -1, and simultaneous push and pop unchanged.
REQ-025 SHALL NOT let changes to in_data after acceptance alter a queued or in-flight byte.

Reset
REQ-026 SHALL, on rst high at any clock edge including mid-frame, set state=IDLE, tx=1, in_ready=0, busy=0, fifo_count=0, and bit and clock counters to 0.
REQ-027 SHALL flush the buffer on reset without transmitting its contents; a truncated frame is not resumed.
REQ-028 SHALL drive in_ready=1 on the first edge after rst deasserts.

Structure
REQ-029 SHALL place the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the CLKS_PER_BIT derivation in a shared UART package/header, also used by uart_rx.
REQ-030 SHALL use one sub-module, sync_fifo (parameters WIDTH=8 and DEPTH): synchronous, single clock, with push/pop/full/empty/count ports.
REQ-031 SHALL size the clock counter as $clog2(CLKS_PER_BIT) bits and the bit index as 3 bits.

Verification (CLK_FREQ=100e6, BAUD_RATE=115200, CLKS_PER_BIT=868)
REQ-032 SHALL cover: push 0x55 once -> tx low at edge N+2, then 0,1,0,1,0,1,0,1,0,1 with each bit 868 cycles; busy low after 8680 cycles.
REQ-033 SHALL cover: push 0xA3 then 0x0F back-to-back -> two frames contiguous (20*868 cycles), second start bit immediately follows the first stop bit.
REQ-034 SHALL cover: in_valid held high for 20 bytes 0x00..0x13 -> 17 accepted (16 queued plus 1 in flight); in_ready low until the first frame's stop bit ends; all 17 received in order by a uart_rx loopback.
REQ-035 SHALL cover: rst pulsed for 1 cycle during bit 3 of a frame with 5 bytes queued -> tx=1 next edge, fifo_count=0, no further frames.
REQ-036 SHALL cover: fill to fifo_count=16, then assert in_valid exactly as a pop occurs -> byte not accepted, fifo_count becomes 15.
REQ-037 SHALL cover: loopback of all 256 byte values through uart_rx -> all data match, no framing error.
